icache_set_assoc: RTL and testbench

Parametrised set-associative instruction cache between the fetch stage and the memory arbiter. It generalises the earlier direct-ish icache in four ways:
- configurable sets, ways, line and address width;
- true LRU replacement;
- an explicit miss FSM with memory-side backpressure;
- a whole-cache flush.
Fetch requests are line-aligned. Responses are whole lines.

---
 rtl/icache_set_assoc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_icache_set_assoc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache: true-LRU replacement, miss FSM with memory backpressure, whole-cache flush.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_set_assoc #(
  parameter int ADDR_WIDTH = 20,
  parameter int LINE_BITS  = 128,
  parameter int NUM_SETS   = 2,
  parameter int NUM_WAYS   = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        req_valid,
  input  logic [ADDR_WIDTH-1:0]                       req_addr,
  output logic                                        icache_ready,
  output logic                                        rsp_valid,
  output logic [LINE_BITS-1:0]                        rsp_data,
  output logic                                        xcpt_bus_error,
  input  logic                                        flush,
  output logic                                        req_valid_miss,
  output logic [ADDR_WIDTH-$clog2(LINE_BITS/8)-1:0]   req_addr_miss,
  input  logic                                        req_ready_miss,
  input  logic                                        rsp_valid_miss,
  input  logic [LINE_BITS-1:0]                        rsp_data_miss,
  input  logic                                        rsp_bus_error
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                                 hit_count,
  output logic [31:0]                                 miss_count
`endif
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int SETB  = $clog2(NUM_SETS);
  localparam int TAGB  = ADDR_WIDTH - OFF - SETB;
  localparam int LINEB = ADDR_WIDTH - OFF;
  localparam int WAYB  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    RESP_FILL,
    FLUSH
  } state_t;

  state_t state;
  state_t next_state;

  logic                 valid [NUM_SETS][NUM_WAYS];
  logic [TAGB-1:0]      tags  [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] lines [NUM_SETS][NUM_WAYS];
  logic [WAYB-1:0]      age   [NUM_SETS][NUM_WAYS];

  logic                 flush_pending;
  logic [SETB-1:0]      lat_set;
  logic [WAYB-1:0]      lat_way;

  logic [TAGB-1:0]      req_tag;
  logic [SETB-1:0]      req_set;
  logic [OFF-1:0]       unused_off;
  logic                 hit;
  logic [WAYB-1:0]      hit_way;
  logic [LINE_BITS-1:0] hit_line;
  logic [WAYB-1:0]      victim;
  logic                 found_invalid;

  logic                 accept;
  logic                 hit_acc;
  logic                 miss_acc;
  logic                 fill_done;
  logic                 fill_ok;
  logic                 touch_en;
  logic [SETB-1:0]      touch_set;
  logic [WAYB-1:0]      touch_way;

  assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAGB];
  assign req_set    = req_addr[OFF +: SETB];
  assign unused_off = req_addr[OFF-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[req_set][w] && (tags[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYB'(w);
      end
    end
  end

  assign hit_line = lines[req_set][hit_way];

  // Oldest way is the fallback; the lowest-index invalid way overrides it.
  always_comb begin
    victim        = '0;
    found_invalid = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age[req_set][w] == WAYB'(NUM_WAYS - 1)) begin
        victim = WAYB'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found_invalid && !valid[req_set][w]) begin
        victim        = WAYB'(w);
        found_invalid = 1'b1;
      end
    end
  end

  assign accept    = req_valid && icache_ready;
  assign hit_acc   = accept && hit;
  assign miss_acc  = accept && !hit;
  assign fill_done = (state == MISS_WAIT) && rsp_valid_miss;
  assign fill_ok   = fill_done && !rsp_bus_error;

  assign touch_en  = hit_acc || fill_ok;
  assign touch_set = hit_acc ? req_set : lat_set;
  assign touch_way = hit_acc ? hit_way : lat_way;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (flush || flush_pending) begin
          next_state = FLUSH;
        end else if (miss_acc) begin
          next_state = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (req_ready_miss) begin
          next_state = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (rsp_valid_miss) begin
          next_state = RESP_FILL;
        end
      end
      RESP_FILL: begin
        next_state = (flush_pending || flush) ? FLUSH : IDLE;
      end
      FLUSH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // A flush arriving in the same cycle as a request wins, so ready drops with it.
  always_comb begin
    icache_ready = (state == IDLE) && !flush_pending && !flush && !reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_pending <= 1'b0;
    end else if (state == FLUSH) begin
      flush_pending <= flush;
    end else if ((state != IDLE) && flush) begin
      flush_pending <= 1'b1;
    end
  end

  // Ages form a permutation per set; cleared state is age == way index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[s][w] <= 1'b0;
          age[s][w]   <= WAYB'(w);
        end
      end
    end else if (state == FLUSH) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid[s][w] <= 1'b0;
          age[s][w]   <= WAYB'(w);
        end
      end
    end else begin
      if (fill_ok) begin
        valid[lat_set][lat_way] <= 1'b1;
      end
      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAYB'(w) == touch_way) begin
            age[touch_set][w] <= '0;
          end else if (age[touch_set][w] < age[touch_set][touch_way]) begin
            age[touch_set][w] <= age[touch_set][w] + WAYB'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill_ok) begin
      tags[lat_set][lat_way]  <= req_addr_miss[LINEB-1 -: TAGB];
      lines[lat_set][lat_way] <= rsp_data_miss;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      xcpt_bus_error <= 1'b0;
      req_valid_miss <= 1'b0;
      req_addr_miss  <= '0;
      lat_set        <= '0;
      lat_way        <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      xcpt_bus_error <= 1'b0;
      if (hit_acc) begin
        rsp_valid <= 1'b1;
        rsp_data  <= hit_line;
      end
      if (fill_done) begin
        rsp_valid      <= 1'b1;
        xcpt_bus_error <= rsp_bus_error;
        rsp_data       <= rsp_bus_error ? '0 : rsp_data_miss;
      end
      if (miss_acc) begin
        req_valid_miss <= 1'b1;
        req_addr_miss  <= req_addr[ADDR_WIDTH-1:OFF];
        lat_set        <= req_set;
        lat_way        <= victim;
      end else if ((state == MISS_REQ) && req_ready_miss) begin
        req_valid_miss <= 1'b0;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_acc && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc; responses are checked against a queue of expected lines.
module tb_icache_set_assoc;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [19:0]  req_addr = '0;
  logic         icache_ready;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic         xcpt_bus_error;
  logic         flush = 1'b0;
  logic         req_valid_miss;
  logic [15:0]  req_addr_miss;
  logic         req_ready_miss = 1'b0;
  logic         rsp_valid_miss = 1'b0;
  logic [127:0] rsp_data_miss = '0;
  logic         rsp_bus_error = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  typedef struct packed {
    logic [127:0] data;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_D0 = {4{32'hD000_0D00}};
  localparam logic [127:0] LINE_D1 = {4{32'hD111_1D11}};
  localparam logic [127:0] LINE_D2 = {4{32'hD222_2D22}};
  localparam logic [127:0] LINE_D3 = {4{32'hD333_3D33}};
  localparam logic [127:0] LINE_B7 = {8{16'hB7C8}};
  localparam logic [127:0] LINE_E1 = {4{32'h0E1E_1E1E}};

  icache_set_assoc dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .icache_ready   (icache_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .xcpt_bus_error (xcpt_bus_error),
    .flush          (flush),
    .req_valid_miss (req_valid_miss),
    .req_addr_miss  (req_addr_miss),
    .req_ready_miss (req_ready_miss),
    .rsp_valid_miss (rsp_valid_miss),
    .rsp_data_miss  (rsp_data_miss),
    .rsp_bus_error  (rsp_bus_error)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", {127'd0, rsp_valid}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp_data", rsp_data, e.data);
        check_output("rsp_xcpt", {127'd0, xcpt_bus_error}, {127'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && icache_ready !== 1'b1; i++) tick();
    check_output("ready_wait", {127'd0, icache_ready}, 128'd1);
  endtask

  task automatic hit_req(input logic [19:0] addr, input logic [127:0] data);
    req_valid = 1'b1;
    req_addr  = addr;
    wait_ready();
    exp_q.push_back(rsp_t'({data, 1'b0}));
    tick();
    req_valid = 1'b0;
    check_output("hit_rsp_valid", {127'd0, rsp_valid}, 128'd1);
    check_output("hit_no_fill_req", {127'd0, req_valid_miss}, 128'd0);
  endtask

  task automatic miss_req(input logic [19:0] addr, input logic [127:0] data, input bit err,
                          input int stall, input bit flush_wait);
    logic [15:0] line;
    line      = addr[19:4];
    req_valid = 1'b1;
    req_addr  = addr;
    wait_ready();
    tick();
    req_valid = 1'b0;
    check_output("miss_req_valid", {127'd0, req_valid_miss}, 128'd1);
    check_output("miss_req_addr", {112'd0, req_addr_miss}, {112'd0, line});
    check_output("miss_busy", {127'd0, icache_ready}, 128'd0);
    check_output("miss_no_rsp", {127'd0, rsp_valid}, 128'd0);
    for (int i = 0; i < stall; i++) begin
      rsp_valid_miss = (i == 0);
      rsp_data_miss  = ~data;
      tick();
      rsp_valid_miss = 1'b0;
      check_output("stall_req_valid", {127'd0, req_valid_miss}, 128'd1);
      check_output("stall_req_addr", {112'd0, req_addr_miss}, {112'd0, line});
      check_output("stall_busy", {127'd0, icache_ready}, 128'd0);
    end
    req_ready_miss = 1'b1;
    tick();
    req_ready_miss = 1'b0;
    check_output("miss_req_drop", {127'd0, req_valid_miss}, 128'd0);
    if (flush_wait) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    rsp_valid_miss = 1'b1;
    rsp_data_miss  = data;
    rsp_bus_error  = err;
    exp_q.push_back(rsp_t'({(err ? 128'd0 : data), err}));
    tick();
    rsp_valid_miss = 1'b0;
    rsp_bus_error  = 1'b0;
    check_output("fill_rsp_valid", {127'd0, rsp_valid}, 128'd1);
    check_output("fill_ready_low", {127'd0, icache_ready}, 128'd0);
    tick();
    if (flush_wait) begin
      check_output("flush_cycle_ready", {127'd0, icache_ready}, 128'd0);
      check_output("flush_cycle_rsp", {127'd0, rsp_valid}, 128'd0);
      tick();
    end
    check_output("back_to_idle", {127'd0, icache_ready}, 128'd1);
  endtask

  initial begin
    $display("[TB] start");
    #3;
    check_output("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check_output("rst_xcpt", {127'd0, xcpt_bus_error}, 128'd0);
    check_output("rst_rsp_data", rsp_data, 128'd0);
    check_output("rst_req_valid_miss", {127'd0, req_valid_miss}, 128'd0);
    check_output("rst_req_addr_miss", {112'd0, req_addr_miss}, 128'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check_output("post_rst_ready", {127'd0, icache_ready}, 128'd1);

    $display("[TB] cold miss then hit");
    miss_req(20'h00100, LINE_A5, 1'b0, 0, 1'b0);
    hit_req(20'h00100, LINE_A5);
    tick();

    $display("[TB] flush in idle with a colliding request");
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 20'h00100;
    #1;
    check_output("flush_blocks_ready", {127'd0, icache_ready}, 128'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check_output("flush_state_ready", {127'd0, icache_ready}, 128'd0);
    check_output("flush_req_ignored", {127'd0, rsp_valid}, 128'd0);
    tick();
    check_output("flush_done_ready", {127'd0, icache_ready}, 128'd1);

    $display("[TB] LRU eviction in set 0");
    miss_req(20'h00000, LINE_D0, 1'b0, 0, 1'b0);
    miss_req(20'h00020, LINE_D1, 1'b0, 0, 1'b0);
    hit_req(20'h00000, LINE_D0);
    miss_req(20'h00040, LINE_D2, 1'b0, 0, 1'b0);
    hit_req(20'h00000, LINE_D0);
    hit_req(20'h00040, LINE_D2);
    miss_req(20'h00020, LINE_D3, 1'b0, 0, 1'b0);

    $display("[TB] bus error");
    miss_req(20'h00100, LINE_A5, 1'b1, 0, 1'b0);
    miss_req(20'h00100, LINE_B7, 1'b0, 0, 1'b0);
    hit_req(20'h00100, LINE_B7);

    $display("[TB] memory backpressure");
    miss_req(20'h00030, LINE_E1, 1'b0, 5, 1'b0);
    hit_req(20'h00030, LINE_E1);

    $display("[TB] deferred flush");
    miss_req(20'h00050, LINE_D1, 1'b0, 0, 1'b1);
    miss_req(20'h00050, LINE_D2, 1'b0, 0, 1'b0);
    hit_req(20'h00050, LINE_D2);
    tick();

    $display("[TB] async reset during fill request");
    req_valid = 1'b1;
    req_addr  = 20'h00070;
    wait_ready();
    tick();
    req_valid = 1'b0;
    check_output("pre_rst_req_valid", {127'd0, req_valid_miss}, 128'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_rst_req_valid", {127'd0, req_valid_miss}, 128'd0);
    check_output("async_rst_req_addr", {112'd0, req_addr_miss}, 128'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    miss_req(20'h00050, LINE_D3, 1'b0, 0, 1'b0);
    hit_req(20'h00050, LINE_D3);
    hit_req(20'h00050, LINE_D3);
    hit_req(20'h00050, LINE_D3);
    miss_req(20'h00060, LINE_D0, 1'b0, 0, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    check_output("hit_count", {96'd0, hit_count}, 128'd3);
    check_output("miss_count", {96'd0, miss_count}, 128'd2);
`endif
    tick();
    tick();
    check_output("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
